// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO management master between N_REQ requesters.
// Each requester owns a single command slot; the FSM sequences the master's strobe/busy handshake.
module mdio_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned START_TMO = 16,
    parameter int unsigned DONE_TMO  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_wr,
    input  logic [5*N_REQ-1:0]    req_phy,
    input  logic [5*N_REQ-1:0]    req_reg,
    input  logic [16*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      pend,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic [15:0]           rdata,
    output logic [4:0]            phy_add_o,
    output logic [4:0]            reg_add,
    output logic [15:0]           wr_data,
    output logic                  wren,
    output logic                  rden,
    input  logic                  busy,
    input  logic [15:0]           mdio_rd_data
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(DONE_TMO);
    localparam logic [IW-1:0] LAST_RST  = IW'(N_REQ - 1);
    localparam logic [TW-1:0] START_LIM = TW'(START_TMO - 1);
    localparam logic [TW-1:0] DONE_LIM  = TW'(DONE_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] gnt;
    logic [TW-1:0] timer;
    logic          cur_wr;

    logic          slot_wr    [N_REQ];
    logic [4:0]    slot_phy   [N_REQ];
    logic [4:0]    slot_reg   [N_REQ];
    logic [15:0]   slot_wdata [N_REQ];

    logic [IW-1:0] win_c;
    logic          any_c;
    int unsigned   idx_c;

    // Round-robin search starting one past the most recently granted requester.
    always_comb begin
        win_c = last;
        any_c = 1'b0;
        idx_c = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx_c = 32'(last) + k;
            if (idx_c >= N_REQ) begin
                idx_c = idx_c - N_REQ;
            end
            if (!any_c && pend[IW'(idx_c)]) begin
                any_c = 1'b1;
                win_c = IW'(idx_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= LAST_RST;
            gnt       <= '0;
            timer     <= '0;
            cur_wr    <= 1'b0;
            pend      <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            phy_add_o <= '0;
            reg_add   <= '0;
            wr_data   <= '0;
            wren      <= 1'b0;
            rden      <= 1'b0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_wr[i]    <= 1'b0;
                slot_phy[i]   <= '0;
                slot_reg[i]   <= '0;
                slot_wdata[i] <= '0;
            end
        end else begin
            wren <= 1'b0;
            rden <= 1'b0;
            done <= '0;
            err  <= '0;

            // A request is only accepted into an empty slot.
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req[i] && !pend[i]) begin
                    pend[i]       <= 1'b1;
                    slot_wr[i]    <= req_wr[i];
                    slot_phy[i]   <= req_phy[5*i +: 5];
                    slot_reg[i]   <= req_reg[5*i +: 5];
                    slot_wdata[i] <= req_wdata[16*i +: 16];
                end
            end

            case (state)
                S_IDLE: begin
                    if (any_c && !busy) begin
                        gnt       <= win_c;
                        last      <= win_c;
                        cur_wr    <= slot_wr[win_c];
                        phy_add_o <= slot_phy[win_c];
                        reg_add   <= slot_reg[win_c];
                        wr_data   <= slot_wr[win_c] ? slot_wdata[win_c] : 16'h0000;
                        wren      <= slot_wr[win_c];
                        rden      <= !slot_wr[win_c];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (busy) begin
                        timer <= '0;
                        state <= S_WAIT_DONE;
                    end else if (timer == START_LIM) begin
                        done[gnt] <= 1'b1;
                        err[gnt]  <= 1'b1;
                        state     <= S_COMPLETE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        done[gnt] <= 1'b1;
                        if (!cur_wr) begin
                            rdata <= mdio_rd_data;
                        end
                        state <= S_COMPLETE;
                    end else if (timer == DONE_LIM) begin
                        done[gnt] <= 1'b1;
                        err[gnt]  <= 1'b1;
                        state     <= S_COMPLETE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_COMPLETE: begin
                    // done/err/rdata were registered on entry; release the slot on exit.
                    pend[gnt] <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter with a behavioural MDIO master model.
module tb_mdio_arbiter;

    localparam int N    = 3;
    localparam int STMO = 8;
    localparam int DTMO = 64;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_wr;
    logic [5*N-1:0]  req_phy;
    logic [5*N-1:0]  req_reg;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]  pend;
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic [15:0]   rdata;
    logic [4:0]    phy_add_o;
    logic [4:0]    reg_add;
    logic [15:0]   wr_data;
    logic          wren;
    logic          rden;
    logic          busy;
    logic [15:0]   mdio_rd_data;

    mdio_arbiter #(.N_REQ(N), .START_TMO(STMO), .DONE_TMO(DTMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_phy(req_phy),
        .req_reg(req_reg), .req_wdata(req_wdata), .pend(pend), .done(done),
        .err(err), .rdata(rdata), .phy_add_o(phy_add_o), .reg_add(reg_add),
        .wr_data(wr_data), .wren(wren), .rden(rden), .busy(busy),
        .mdio_rd_data(mdio_rd_data)
    );

    typedef struct {
        int          idx;
        bit          wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        bit          er;
        logic [15:0] rd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tb_last = N - 1;
    bit          exp_err = 0;
    logic [15:0] rd_model = '0;
    logic [15:0] regfile [32];

    bit          c_wr  [N];
    logic [4:0]  c_phy [N];
    logic [4:0]  c_reg [N];
    logic [15:0] c_wd  [N];

    // master model controls: 0 normal, 1 busy never rises, 2 busy sticks high, 3 release
    int          mode = 0;
    int          rise_dly = 2;
    int          hold_len = 5;
    int          rise_cnt = 0;
    int          hold_cnt = 0;
    logic [4:0]  cur_reg = '0;
    int          fall_cyc = -10;
    int          strobe_cnt = 0;
    int          strobe_cyc = 0;
    int          done_cyc = 0;
    bit          outstanding = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (wren || rden) begin
            check("strobe_excl", 32'(wren & rden), 32'd0);
            if (outstanding) check("double_strobe", 32'd1, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = q[0];
                check("strobe_kind", 32'({wren, rden}), 32'({e.wr, !e.wr}));
                check("strobe_phy", 32'(phy_add_o), 32'(e.phy));
                check("strobe_reg", 32'(reg_add), 32'(e.rg));
                check("strobe_wdata", 32'(wr_data), 32'(e.wr ? e.wd : 16'h0));
            end
            strobe_cnt++;
            strobe_cyc  = cyc;
            outstanding = 1;
        end
        if (done != '0) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                check("done_idx", 32'(done), 32'(1) << e.idx);
                check("done_err", 32'(err), e.er ? (32'(1) << e.idx) : 32'd0);
                if (!e.er && !e.wr) rd_model = e.rd;
                check("done_rdata", 32'(rdata), 32'(rd_model));
                check("hold_phy", 32'(phy_add_o), 32'(e.phy));
                check("hold_reg", 32'(reg_add), 32'(e.rg));
                check("hold_wdata", 32'(wr_data), 32'(e.wr ? e.wd : 16'h0));
                if (!e.er) check("done_latency", 32'(cyc), 32'(fall_cyc + 1));
            end
            done_cyc    = cyc;
            outstanding = 0;
        end else if (err != '0) begin
            check("err_without_done", 32'(err), 32'd0);
        end
    endtask

    task automatic model();
        if (mode == 3) begin
            busy     = 1'b0;
            fall_cyc = cyc;
            rise_cnt = 0;
            mode     = 0;
        end else if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                busy         = 1'b1;
                mdio_rd_data = 16'($urandom);
                hold_cnt     = hold_len;
            end
        end else if (busy && mode != 2) begin
            hold_cnt--;
            if (hold_cnt == 0) begin
                busy         = 1'b0;
                mdio_rd_data = regfile[cur_reg];
                fall_cyc     = cyc;
            end
        end
        if ((wren || rden) && mode != 1) begin
            rise_cnt = rise_dly;
            cur_reg  = reg_add;
        end
    endtask

    initial begin
        busy = 1'b0;
        mdio_rd_data = '0;
        forever begin
            @(negedge clk);
            monitor();
            model();
        end
    end

    task automatic post(input logic [N-1:0] mask, input bit push, output int t);
        exp_t e;
        int   base;
        int   j;
        @(negedge clk);
        t = cyc;
        for (int i = 0; i < N; i++) begin
            req_wr[i]             = c_wr[i];
            req_phy[5*i +: 5]     = c_phy[i];
            req_reg[5*i +: 5]     = c_reg[i];
            req_wdata[16*i +: 16] = c_wd[i];
        end
        req = mask;
        if (push) begin
            base = tb_last;
            for (int k = 1; k <= N; k++) begin
                j = (base + k) % N;
                if (mask[j]) begin
                    e.idx = j; e.wr = c_wr[j]; e.phy = c_phy[j]; e.rg = c_reg[j];
                    e.wd = c_wd[j]; e.er = exp_err; e.rd = regfile[c_reg[j]];
                    q.push_back(e);
                    tb_last = j;
                end
            end
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic drain(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input bit wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
        c_wr[i] = wr; c_phy[i] = phy; c_reg[i] = rg; c_wd[i] = wd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pend"}, 32'(pend), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_phy"}, 32'(phy_add_o), 32'd0);
        check({tag, "_reg"}, 32'(reg_add), 32'd0);
        check({tag, "_wdata"}, 32'(wr_data), 32'd0);
        check({tag, "_strobes"}, 32'({wren, rden}), 32'd0);
    endtask

    initial begin
        int t;
        int s;
        rst = 1'b1; req = '0; req_wr = '0; req_phy = '0; req_reg = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) regfile[i] = 16'($urandom);
        regfile[1] = 16'h796D;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 5'd0, 5'd0, 16'h0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // single write with latency checks
        set_cmd(0, 1'b1, 5'h0F, 5'h00, 16'h1100);
        rise_dly = 2; hold_len = $urandom_range(3, 40);
        post(3'b001, 1, t);
        check("t1_pend_set", 32'(pend), 32'b001);
        drain(200);
        check("t1_strobe_latency", 32'(strobe_cyc), 32'(t + 2));
        check("t1_pend_clear", 32'(pend), 32'd0);

        // single read, rdata held afterwards
        set_cmd(1, 1'b0, 5'h0F, 5'h01, 16'hFFFF);
        hold_len = $urandom_range(3, 40);
        post(3'b010, 1, t);
        drain(200);
        repeat (5) @(negedge clk);
        check("t2_rdata_held", 32'(rdata), 32'h796D);

        set_cmd(2, 1'b1, 5'h02, 5'h07, 16'hBEEF);
        post(3'b100, 1, t);
        drain(200);

        // round-robin: two simultaneous batches
        for (int b = 0; b < 2; b++) begin
            set_cmd(0, b == 0, 5'h01, 5'h03 + 5'(b), 16'hA5A5 ^ 16'(b));
            set_cmd(1, b == 1, 5'h02, 5'h03, 16'h1234);
            set_cmd(2, 1'b0, 5'h03, 5'h04 + 5'(b), 16'h5555);
            rise_dly = $urandom_range(1, 4); hold_len = $urandom_range(3, 12);
            post(3'b111, 1, t);
            drain(400);
            check("t3_pend_clear", 32'(pend), 32'd0);
        end

        // collision: re-pulse ignored, queued requester served next
        rise_dly = 2; hold_len = 20;
        set_cmd(0, 1'b1, 5'h0A, 5'h0B, 16'hC0DE);
        post(3'b001, 1, t);
        set_cmd(0, 1'b0, 5'h11, 5'h12, 16'h0BAD);
        post(3'b001, 0, t);
        set_cmd(2, 1'b0, 5'h04, 5'h01, 16'h0);
        post(3'b100, 1, t);
        check("t4_pend_both", 32'(pend), 32'b101);
        drain(400);
        check("t4_pend_clear", 32'(pend), 32'd0);

        // start timeout: busy never rises
        mode = 1; exp_err = 1;
        set_cmd(1, 1'b0, 5'h05, 5'h05, 16'h0);
        post(3'b010, 1, t);
        drain(200);
        check("t5_done_time", 32'(done_cyc), 32'(t + STMO + 3));
        check("t5_rdata_kept", 32'(rdata), 32'(rd_model));
        mode = 0; exp_err = 0;

        // done timeout: busy stuck, next command waits for busy low
        mode = 2; exp_err = 1; rise_dly = 1; hold_len = 3;
        set_cmd(0, 1'b1, 5'h06, 5'h08, 16'h7777);
        post(3'b001, 1, t);
        drain(300);
        exp_err = 0;
        set_cmd(2, 1'b0, 5'h07, 5'h01, 16'h0);
        s = strobe_cnt;
        post(3'b100, 1, t);
        repeat (20) @(negedge clk);
        check("t6_no_issue_busy", 32'(strobe_cnt), 32'(s));
        mode = 3;
        drain(200);
        check("t6_rdata", 32'(rdata), 32'h796D);

        // reset in WAIT_DONE
        mode = 2; rise_dly = 1;
        set_cmd(0, 1'b0, 5'h08, 5'h02, 16'h0);
        post(3'b001, 1, t);
        for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
        check("t7_busy_rose", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t7");
        q.delete(); outstanding = 0; rd_model = '0; tb_last = N - 1;
        rst = 1'b0;
        set_cmd(1, 1'b0, 5'h09, 5'h01, 16'h0);
        s = strobe_cnt;
        post(3'b010, 1, t);
        repeat (10) @(negedge clk);
        check("t7_no_issue_busy", 32'(strobe_cnt), 32'(s));
        mode = 3;
        drain(200);
        check("t7_rdata", 32'(rdata), 32'h796D);
        check("t7_pend_clear", 32'(pend), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
